// File: rtl/async_ram_pkg.sv
// Shared types and constants for the async RAM initiator.
// State list includes the verify states used when ASYNC_RAM_CTRL_READBACK_EN is defined.
package async_ram_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD,
    ST_READ,
    ST_CAPTURE,
    ST_VSETUP,
    ST_VREAD,
    ST_VCMP
  } state_e;

  // One bit of headroom over what the longest timed phase needs.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/async_ram_ctrl_timer.sv
// Loadable down-counter for timed bus phases; done is high in the last cycle
// of a phase that was loaded with (cycles - 1).
module async_ram_ctrl_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/async_ram_ctrl.sv
// Clocked valid/ready front end that sequences cs/we/addr/data cycles on an async RAM.
// Define ASYNC_RAM_CTRL_READBACK_EN to verify every write with an automatic read-back.
module async_ram_ctrl
  import async_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WR_PULSE   = 2,
  parameter int RD_WAIT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  localparam int CW = cnt_width(WR_PULSE, RD_WAIT);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);

  state_e                  state_q,     state_d;
  logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
  logic                    we_op_q,     we_op_d;
  logic                    ready_q,     ready_d;
  logic                    cs_q,        cs_d;
  logic                    we_q,        we_d;
  logic                    drive_en_q,  drive_en_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_we_q,    rsp_we_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                    accept;
  logic                    timer_load;
  logic [CW-1:0]           timer_val;
  logic                    timer_done;

  assign accept = (state_q == ST_IDLE) && ready_q && req_valid;

  async_ram_ctrl_timer #(
    .W (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_SETUP;
      ST_SETUP:   state_d = we_op_q ? ST_WRITE : ST_READ;
      ST_WRITE:   if (timer_done) state_d = ST_HOLD;
`ifdef ASYNC_RAM_CTRL_READBACK_EN
      ST_HOLD:    state_d = ST_VSETUP;
      ST_VSETUP:  state_d = ST_VREAD;
      ST_VREAD:   if (timer_done) state_d = ST_VCMP;
      ST_VCMP:    state_d = ST_IDLE;
`else
      ST_HOLD:    state_d = ST_IDLE;
`endif
      ST_READ:    if (timer_done) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The timer is reloaded on every state entry with that phase's length.
  always_comb begin
    timer_load = (state_d != state_q);
    case (state_d)
      ST_WRITE:         timer_val = WR_LOAD;
      ST_READ, ST_VREAD: timer_val = RD_LOAD;
      default:          timer_val = '0;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_op_d = we_op_q;
    if (accept) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      we_op_d = req_we;
    end
  end

  // Bus controls are registered from the next state so they change cleanly on edges;
  // addr changes only on the accept edge, one cycle before we can rise.
  always_comb begin
    ready_d    = (state_d == ST_IDLE);
    cs_d       = (state_d != ST_IDLE);
    we_d       = (state_d == ST_WRITE);
    drive_en_d = we_op_d &&
                 ((state_d == ST_SETUP) || (state_d == ST_WRITE) || (state_d == ST_HOLD));
`ifdef ASYNC_RAM_CTRL_READBACK_EN
    rsp_valid_d = (state_d == ST_CAPTURE) || (state_d == ST_VCMP);
`else
    rsp_valid_d = (state_d == ST_CAPTURE) || (state_d == ST_HOLD);
`endif
    rsp_we_d    = rsp_valid_d && we_op_q;
    rsp_rdata_d = (state_d == ST_CAPTURE) ? ram_data : rsp_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_op_q     <= 1'b0;
      ready_q     <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      drive_en_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_op_q     <= we_op_d;
      ready_q     <= ready_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      drive_en_q  <= drive_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef ASYNC_RAM_CTRL_READBACK_EN
  logic rsp_err_q, rsp_err_d;

  // Verify data is sampled on the edge entering the compare state, like a read capture.
  always_comb begin
    rsp_err_d = (state_d == ST_VCMP) && (ram_data != wdata_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_cs    = cs_q;
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_data  = drive_en_q ? wdata_q : 'z;

endmodule

// File: tb/tb_async_ram_ctrl.sv
// Randomized bench for async_ram_ctrl with a cycle-indexed reference model and a
// behavioural async RAM on a pulled-up bus (undriven bus reads as all ones).
module tb_async_ram_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int WP = 2;
  localparam int RD = 2;

`ifdef ASYNC_RAM_CTRL_READBACK_EN
  localparam int WR_LEN      = 4 + WP + RD;
  localparam int WR_RSP_LIT  = 7;
  localparam int SPAN_LIT    = 51;
`else
  localparam int WR_LEN      = 2 + WP;
  localparam int WR_RSP_LIT  = 3;
  localparam int SPAN_LIT    = 35;
`endif
  localparam int RD_LEN = 2 + RD;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  for (genvar gi = 0; gi < DW; gi++) begin : g_pull
    pullup pu (ram_data[gi]);
  end

  async_ram_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WR_PULSE   (WP),
    .RD_WAIT    (RD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_we    (rsp_we),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_mis++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp_v);
    end
  endtask

  // Reference model: outputs as a function of cycles since the accept edge.
  bit            in_fl   = 1'b0;
  bit            op_we   = 1'b0;
  int            k       = 0;
  int            len     = 0;
  bit            m_acc   = 1'b0;
  bit            e_ready = 1'b0;
  bit            e_cs    = 1'b0;
  bit            e_we    = 1'b0;
  bit            e_drive = 1'b0;
  bit            e_rv    = 1'b0;
  bit            e_rwe   = 1'b0;
  bit            e_err   = 1'b0;
  logic [DW-1:0] e_rdata = '0;
  logic [DW-1:0] e_wdata = '0;
  logic [AW-1:0] e_addr  = '0;
  logic [DW-1:0] mem_exp [16];
  bit            flip7   = 1'b0;

  function automatic logic [DW-1:0] rd_exp(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = mem_exp[a];
    if (flip7 && a == 4'h7) v = v ^ 8'h01;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem_exp[i] = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        in_fl   = 1'b0;
        k       = 0;
        m_acc   = 1'b0;
        e_ready = 1'b0;
        e_rdata = '0;
      end else begin
        cyc++;
        m_acc = 1'b0;
        if (in_fl) begin
          k++;
          if (k > len) in_fl = 1'b0;
        end else if (e_ready && req_valid) begin
          in_fl   = 1'b1;
          k       = 1;
          op_we   = req_we;
          e_addr  = req_addr;
          e_wdata = req_wdata;
          len     = req_we ? WR_LEN : RD_LEN;
          m_acc   = 1'b1;
          if (req_we) mem_exp[req_addr] = req_wdata;
        end
        e_ready = !in_fl;
        if (in_fl && !op_we && k == len) e_rdata = rd_exp(e_addr);
      end
      e_cs    = in_fl;
      e_we    = in_fl && op_we && k >= 2 && k <= 1 + WP;
      e_drive = in_fl && op_we && k <= 2 + WP;
      e_rv    = in_fl && k == len;
      e_rwe   = op_we;
      e_err   = e_rv && op_we && (rd_exp(e_addr) != e_wdata);
    end
  end

  // Behavioural async RAM: drives the bus only when selected, not writing, and the
  // controller is not supposed to be driving.
  logic [DW-1:0] ram_mem [16];
  logic [DW-1:0] ram_rd;
  logic          ram_oe;
  assign ram_rd   = ram_mem[ram_addr] ^ ((flip7 && ram_addr == 4'h7) ? 8'h01 : 8'h00);
  assign ram_oe   = ram_cs && !ram_we && !e_drive;
  assign ram_data = ram_oe ? ram_rd : 'z;
  always @(posedge clk) if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("ready",     int'(req_ready), int'(e_ready));
      chk("cs",        int'(ram_cs),    int'(e_cs));
      chk("we",        int'(ram_we),    int'(e_we));
      chk("rsp_valid", int'(rsp_valid), int'(e_rv));
      chk("rsp_rdata", int'(rsp_rdata), int'(e_rdata));
      chk("rsp_err",   int'(rsp_err),   int'(e_err));
      if (e_cs) chk("addr", int'(ram_addr), int'(e_addr));
      if (e_rv) chk("rsp_we", int'(rsp_we), int'(e_rwe));
      if (e_drive)     chk("bus_wr", int'(ram_data), int'(e_wdata));
      else if (ram_oe) chk("bus_rd", int'(ram_data), int'(ram_rd));
      else             chk("bus_z",  int'(ram_data), 255);
    end
  end

  // Accept counter for the back-to-back stream.
  bit acc_arm = 1'b0;
  int acc_n = 0, acc_first = 0, acc_last = 0;
  initial forever begin
    @(negedge clk);
    if (!acc_arm) begin
      acc_n = 0;
    end else if (rst && req_valid && req_ready) begin
      if (acc_n == 0) acc_first = cyc;
      acc_last = cyc;
      acc_n++;
    end
  end

  task automatic do_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit keep);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_acc && n < 100);
    if (!m_acc) begin
      n_mis++;
      $display("FAIL accept_wait: no accept after %0d cycles", n);
    end
    $display("op @%0d: %s addr=0x%0h data=0x%0h", cyc, we ? "WR" : "RD", a, d);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rsp_valid && n < 40);
    chk("rsp_seen", int'(rsp_valid), 1);
  endtask

  initial begin
    int n;
    int perm [16];
    int j, t;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_cs",    int'(ram_cs),    0);
    chk("rst_we",    int'(ram_we),    0);
    chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_rdata", int'(rsp_rdata), 0);
    chk("rst_bus",   int'(ram_data),  255);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", int'(req_ready), 1);

    // Reset in the middle of the write pulse.
    do_op(1'b1, 4'h9, 8'h3C, 1'b0);
    @(posedge clk);
    #2;
    chk("we_before_rst", int'(ram_we), 1);
    rst = 1'b0;
    #1;
    chk("midrst_we",    int'(ram_we),    0);
    chk("midrst_cs",    int'(ram_cs),    0);
    chk("midrst_bus",   int'(ram_data),  255);
    chk("midrst_valid", int'(rsp_valid), 0);
    chk("midrst_ready", int'(req_ready), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_midrst", int'(req_ready), 1);

    // Directed write then read of the same location.
    do_op(1'b1, 4'h3, 8'hA5, 1'b0);
    wait_rsp(n);
    chk("wr_rsp_edges", n, WR_RSP_LIT);
    chk("wr_rsp_we", int'(rsp_we), 1);
    do_op(1'b0, 4'h3, 8'h00, 1'b0);
    wait_rsp(n);
    chk("rd_rsp_edges", n, 3);
    chk("rd_rsp_we", int'(rsp_we), 0);
    chk("rd_data", int'(rsp_rdata), 8'hA5);

    // Fill every address, then read back in a shuffled order.
    for (int i = 0; i < 16; i++) begin
      a = AW'(i);
      do_op(1'b1, a, {4'h0, a} ^ 8'h5A, 1'b0);
    end
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 16; i++) begin
      a = AW'(perm[i]);
      do_op(1'b0, a, 8'h00, 1'b0);
      wait_rsp(n);
      chk("fill_rd", int'(rsp_rdata), int'({4'h0, a} ^ 8'h5A));
    end

    // Random traffic with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(15, 0));
      d = DW'($urandom_range(254, 0));
      do_op(1'($urandom_range(1, 0)), a, d, 1'b0);
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
    end

    // Continuous valid with alternating write/read.
    repeat (12) @(posedge clk);
    #1 acc_arm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = AW'($urandom_range(15, 0));
      d = DW'($urandom_range(254, 0));
      do_op((i % 2) == 0, a, d, i != 7);
    end
    chk("stream_acc",  acc_n, 8);
    chk("stream_span", acc_last - acc_first, SPAN_LIT);
    acc_arm = 1'b0;

`ifdef ASYNC_RAM_CTRL_READBACK_EN
    // Read-back verification with a stuck bit on address 7.
    repeat (12) @(posedge clk);
    #1 flip7 = 1'b1;
    do_op(1'b1, 4'h7, 8'h10, 1'b0);
    wait_rsp(n);
    chk("rb_err_addr7", int'(rsp_err), 1);
    do_op(1'b1, 4'h2, 8'h22, 1'b0);
    wait_rsp(n);
    chk("rb_err_addr2", int'(rsp_err), 0);
`endif

    repeat (12) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
